fft_spi_frontend: RTL and testbench

//  SPI-to-core bridge ahead of the fft core. MCU shifts a 64-sample, 16-bit frame (1024 bits, MSB first).

---
 rtl/fft_spi_frontend_if.sv | 29 ++
 rtl/fft_spi_frontend.sv | 145 ++++++++++++++
 tb/tb_fft_spi_frontend.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_spi_frontend_if.sv
`timescale 1ns/1ps
// Pins between the SPI front end, the MCU-side SPI wires and the FFT core's RAM ports.
// The master modport is the front end itself; slave is its environment.
interface fft_spi_frontend_if #(
    parameter int ADDR_W   = 6,
    parameter int SAMPLE_W = 16
);
    logic                sck;
    logic                sdi;
    logic                sdo;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                start;
    logic                fft_done;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic                done;

    modport master (
        input  sck, sdi, fft_done, rd_data,
        output sdo, wr_en, wr_addr, wr_data, start, rd_addr, done
    );

    modport slave (
        output sck, sdi, fft_done, rd_data,
        input  sdo, wr_en, wr_addr, wr_data, start, rd_addr, done
    );
endinterface

// File: rtl/fft_spi_frontend.sv
`timescale 1ns/1ps
// SPI slave front end for the FFT core: oversamples sck/sdi, writes each received sample into the
// core's input RAM, starts the core after a full frame and streams the previous results on sdo.
module fft_spi_frontend #(
    parameter int N_SAMPLES   = 64,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    fft_spi_frontend_if.master bus
);
    localparam int ADDR_W = $clog2(N_SAMPLES);
    localparam int BIT_W  = $clog2(SAMPLE_W);
    localparam int CNT_W  = ADDR_W + BIT_W;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SAMPLE_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RX   = 2'd0,
        ST_WAIT = 2'd1,
        ST_FILL = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sck_prev_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [SAMPLE_W-1:0]    rx_sr_q;
    logic [SAMPLE_W-1:0]    tx_sr_q;
    logic [SAMPLE_W-1:0]    wr_data_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic                   wr_en_q;
    logic                   start_q;
    logic                   start_arm_q;
    logic                   done_q;
    logic                   tx_valid_q;

    logic                   rise_d;
    logic                   fall_d;
    logic                   sdi_d;
    logic [ADDR_W-1:0]      word_idx_d;
    logic [BIT_W-1:0]       bit_idx_d;
    logic [SAMPLE_W-1:0]    rx_word_d;

    assign sdi_d      = sdi_sync_q[SYNC_STAGES-1];
    assign rise_d     = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign fall_d     = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign word_idx_d = bit_cnt_q[CNT_W-1:BIT_W];
    assign bit_idx_d  = bit_cnt_q[BIT_W-1:0];
    assign rx_word_d  = {rx_sr_q[SAMPLE_W-2:0], sdi_d};

    // sck and sdi use the same synchronizer depth so sdi_d is aligned with the detected rise
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    // Frame FSM: receive/transmit shifting, RAM write strobes, core handshake and result preload
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RX;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            start_q     <= 1'b0;
            start_arm_q <= 1'b0;
            done_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            start_q     <= start_arm_q;
            start_arm_q <= 1'b0;
            case (state_q)
                ST_RX: begin
                    if (rise_d) begin
                        rx_sr_q   <= rx_word_d;
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        rd_addr_q <= word_idx_d + ADDR_ONE;
                        done_q    <= 1'b0;
                        if (bit_idx_d == LAST_BIT) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= word_idx_d;
                            wr_data_q <= rx_word_d;
                            if (word_idx_d == LAST_WORD) begin
                                start_arm_q <= 1'b1;
                                state_q     <= ST_WAIT;
                            end
                        end
                    end else if (fall_d) begin
                        // The fall after a completed word brings in the next result, long since fetched
                        if (bit_idx_d == '0 && bit_cnt_q != '0) begin
                            tx_sr_q <= tx_valid_q ? bus.rd_data : '0;
                        end else begin
                            tx_sr_q <= {tx_sr_q[SAMPLE_W-2:0], 1'b0};
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.fft_done) begin
                        done_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        rd_addr_q  <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_sr_q <= bus.rd_data;
                    state_q <= ST_RX;
                end
                default: begin
                    state_q <= ST_RX;
                end
            endcase
        end
    end

    assign bus.sdo     = tx_sr_q[SAMPLE_W-1];
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.start   = start_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_fft_spi_frontend.sv
`timescale 1ns/1ps
// Scoreboard bench for fft_spi_frontend: an SPI master model drives random frames, a core model
// answers with results, and a monitor compares RAM writes, start pulses and sdo words.
module tb_fft_spi_frontend;
    localparam int N = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_spi_frontend_if bus ();
    fft_spi_frontend dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_sdo[$];
    logic [15:0] got_sdo[$];
    logic [15:0] res      [N];
    logic [15:0] frame_w  [N];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   starts = 0;
    int   wr_count = 0;
    int   last_wr_cyc = -10;
    logic [5:0] last_wr_addr = 6'd0;
    bit   tx_valid_m = 1'b0;
    bit   exp_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Result RAM of the core model, one clock of read latency
    always @(posedge clk) bus.rd_data <= res[bus.rd_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a write, a start or an sdo word
    always @(negedge clk) begin : mon
        wr_t e;
        logic [15:0] s;
        if (bus.wr_en === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            last_wr_addr = bus.wr_addr;
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {26'd0, bus.wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {26'd0, bus.wr_addr}, {26'd0, e.addr});
                chk("wr_data", {16'd0, bus.wr_data}, {16'd0, e.data});
            end
        end
        if (bus.start === 1'b1) begin
            starts++;
            chk("start_after_write", cyc - last_wr_cyc, 32'd1);
            chk("start_last_addr", {26'd0, last_wr_addr}, 32'd63);
        end
        if (got_sdo.size() > 0) begin
            s = got_sdo.pop_front();
            if (exp_sdo.size() == 0) begin
                chk("sdo_unexpected", {16'd0, s}, 32'hFFFF_FFFF);
            end else begin
                chk("sdo_word", {16'd0, s}, {16'd0, exp_sdo.pop_front()});
            end
        end
    end

    task automatic do_reset();
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.fft_done = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdo", {31'd0, bus.sdo}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {26'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
        chk("rst_start", {31'd0, bus.start}, 32'd0);
        chk("rst_rd_addr", {26'd0, bus.rd_addr}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        tx_valid_m = 1'b0;
        exp_done = 1'b0;
        exp_wr.delete();
        exp_sdo.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // SPI master: mode-0 style, sdi set with the low phase, sdo captured just before each rise
    task automatic send_bits(input int nbits, input int ph_min, input int ph_max,
                             input bit scored, input bit chk_done);
        logic [15:0] cap;
        int ph;
        int k;
        cap = 16'd0;
        if (scored) begin
            for (int w = 0; w < nbits / 16; w++) begin
                exp_wr.push_back('{addr: 6'(w), data: frame_w[w]});
                exp_sdo.push_back(tx_valid_m ? res[w] : 16'h0000);
            end
        end
        if (chk_done) chk("done_before_frame", {31'd0, bus.done}, {31'd0, exp_done});
        for (int b = 0; b < nbits; b++) begin
            k = (b / 16) % N;
            bus.sdi = frame_w[k][4'(15 - (b % 16))];
            ph = $urandom_range(ph_max, ph_min);
            repeat (ph) @(posedge clk);
            #1;
            cap[4'(15 - (b % 16))] = bus.sdo;
            if (scored && (b % 16) == 15) got_sdo.push_back(cap);
            bus.sck = 1'b1;
            ph = $urandom_range(ph_max, ph_min);
            repeat (ph) @(posedge clk);
            #1;
            if (b == 0 && chk_done) begin
                chk("done_after_first_rise", {31'd0, bus.done}, 32'd0);
                exp_done = 1'b0;
            end
            bus.sck = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Core model: publishes results, raises fft_done and drops it once the DUT reports done
    task automatic core_run(input bit a5);
        int n;
        for (int k = 0; k < N; k++) res[k] = a5 ? (16'hA500 + 16'(k)) : 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        bus.fft_done = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_rise", {31'd0, bus.done}, 32'd1);
        bus.fft_done = 1'b0;
        tx_valid_m = 1'b1;
        exp_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int w0;
        for (int k = 0; k < N; k++) res[k] = 16'h0000;
        do_reset();

        // Test 1: ramp frame, no prior results so sdo is all zero
        for (int k = 0; k < N; k++) frame_w[k] = 16'(k);
        s0 = starts;
        w0 = wr_count;
        send_bits(1024, 4, 4, 1'b1, 1'b1);
        chk("t1_starts", starts - s0, 32'd1);
        chk("t1_writes", wr_count - w0, 32'd64);

        // Test 2: square wave, sdo carries random results from the core model
        core_run(1'b0);
        for (int k = 0; k < N; k++) frame_w[k] = (k < 32) ? 16'h7FFF : 16'h8000;
        s0 = starts;
        send_bits(1024, 4, 4, 1'b1, 1'b1);
        chk("t2_starts", starts - s0, 32'd1);
        chk("t2_last_addr", {26'd0, bus.wr_addr}, 32'd63);

        // Test 4: sck activity while waiting for the core must be ignored
        for (int k = 0; k < N; k++) frame_w[k] = 16'($urandom);
        s0 = starts;
        w0 = wr_count;
        send_bits(40, 4, 6, 1'b0, 1'b0);
        chk("t4_starts", starts - s0, 32'd0);
        chk("t4_writes", wr_count - w0, 32'd0);

        // Test 3: known results stream out on sdo; done falls at the first rise
        core_run(1'b1);
        for (int k = 0; k < N; k++) frame_w[k] = 16'($urandom);
        s0 = starts;
        send_bits(1024, 4, 5, 1'b1, 1'b1);
        chk("t3_starts", starts - s0, 32'd1);

        // Test 5: reset after 500 bits, then a full new frame lands from address 0
        core_run(1'b0);
        for (int k = 0; k < N; k++) frame_w[k] = 16'($urandom);
        s0 = starts;
        send_bits(500, 4, 4, 1'b1, 1'b1);
        do_reset();
        chk("t5_no_start_partial", starts - s0, 32'd0);
        for (int k = 0; k < N; k++) frame_w[k] = 16'($urandom);
        s0 = starts;
        send_bits(1024, 4, 4, 1'b1, 1'b1);
        chk("t5_starts", starts - s0, 32'd1);

        // Test 6: square wave again with phases ranging from minimum to slow
        core_run(1'b0);
        for (int k = 0; k < N; k++) frame_w[k] = (k < 32) ? 16'h7FFF : 16'h8000;
        s0 = starts;
        w0 = wr_count;
        send_bits(1024, 4, 8, 1'b1, 1'b1);
        chk("t6_starts", starts - s0, 32'd1);
        chk("t6_writes", wr_count - w0, 32'd64);

        repeat (10) @(posedge clk);
        #1;
        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("sdo_queue_drained", exp_sdo.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
